// File: rtl/xgmii_tx_pcs_encoder_if.sv
// rtl/xgmii_tx_pcs_encoder_if.sv - XGMII-in / 66b-block-out bundle for the TX PCS encoder
// Purpose: groups the MAC-side word stream and the SERDES-side block handshake.
// Signals:
//   in_xgmii_data[31:0]  MAC word, lane n = bits [8n+7:8n]
//   in_xgmii_ctl[3:0]    per-lane control flag
//   out_xgmii_pcs_ready  word is taken at every rising edge where this is 1
//   out_pcs_block[65:0]  [1:0] sync header, [65:2] scrambled payload
//   out_pcs_valid        out_pcs_block holds a block
//   in_serdes_ready      downstream takes the block when valid && ready
// Modports: master = MAC/SERDES side, slave = encoder.
interface xgmii_tx_pcs_encoder_if;
  logic [31:0] in_xgmii_data;
  logic [3:0]  in_xgmii_ctl;
  logic        out_xgmii_pcs_ready;
  logic [65:0] out_pcs_block;
  logic        out_pcs_valid;
  logic        in_serdes_ready;

  modport master (
    output in_xgmii_data, in_xgmii_ctl, in_serdes_ready,
    input  out_xgmii_pcs_ready, out_pcs_block, out_pcs_valid
  );

  modport slave (
    input  in_xgmii_data, in_xgmii_ctl, in_serdes_ready,
    output out_xgmii_pcs_ready, out_pcs_block, out_pcs_valid
  );
endinterface

// File: rtl/xgmii_tx_pcs_encoder.sv
// rtl/xgmii_tx_pcs_encoder.sv - 10GBASE-R TX PCS: XGMII word pairing, 64b/66b encode, scramble
// Purpose: pairs two 32-bit XGMII words into a 64-bit block, encodes it to a
//   66-bit block, scrambles the payload (x^58+x^39+1) and offers it downstream.
// Ports:
//   tx_clk                transmit clock
//   tx_rst                synchronous active-high reset
//   pcs_if                XGMII input / 66b output bundle (slave modport)
//   out_encode_err_count  saturating count of error blocks emitted
module xgmii_tx_pcs_encoder #(
  parameter bit          SCRAMBLE_BYPASS = 1'b0,
  parameter logic [57:0] SCRAMBLER_SEED  = 58'h3FF_FFFF_FFFF_FFFF,
  parameter int          ERR_CNT_WIDTH   = 16
) (
  input  logic                     tx_clk,
  input  logic                     tx_rst,
  xgmii_tx_pcs_encoder_if.slave    pcs_if,
  output logic [ERR_CNT_WIDTH-1:0] out_encode_err_count
);

  typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_e;

  phase_e                   phase_q, phase_d;
  logic [31:0]              lo_data_q;
  logic [3:0]               lo_ctl_q;
  logic [65:0]              block_q;
  logic                     valid_q;
  logic [57:0]              scr_q, scr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic accept;
  logic capture_lo;
  logic load_blk;

  // Backpressure: a word may only be taken when the output register is free
  // or is being drained this same edge.
  assign accept                     = !tx_rst && (!valid_q || pcs_if.in_serdes_ready);
  assign pcs_if.out_xgmii_pcs_ready = accept;
  assign pcs_if.out_pcs_block       = block_q;
  assign pcs_if.out_pcs_valid       = valid_q;
  assign out_encode_err_count       = err_cnt_q;

  // ---------------- phase FSM ----------------
  always_ff @(posedge tx_clk) begin
    if (tx_rst) phase_q <= PH_LO;
    else        phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (accept) phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
  end

  always_comb begin
    capture_lo = accept && (phase_q == PH_LO);
    load_blk   = accept && (phase_q == PH_HI);
  end

  // ---------------- 64b/66b encoder ----------------
  logic [63:0]      blk_data;
  logic [7:0]       blk_ctl;
  logic [7:0][7:0]  lane;
  logic [55:0]      ctl_codes;
  logic             all_ctl_ok;
  logic             tail_idle;
  logic             term_hit;
  logic [2:0]       term_k;
  logic [7:0]       term_type;
  logic [63:0]      term_mask;
  logic [63:0]      term_data;
  logic [1:0]       enc_sync;
  logic [63:0]      enc_payload;
  logic             enc_err;

  always_comb begin
    blk_data   = {pcs_if.in_xgmii_data, lo_data_q};
    blk_ctl    = {pcs_if.in_xgmii_ctl, lo_ctl_q};
    lane       = blk_data;

    // Map every lane to its 7-bit control code; any code other than /I/ or
    // /E/ rules the block out of the all-control format.
    all_ctl_ok = 1'b1;
    ctl_codes  = '0;
    for (int n = 0; n < 8; n++) begin
      if (lane[n] == 8'h07)      ctl_codes[7*n +: 7] = 7'h00;
      else if (lane[n] == 8'hFE) ctl_codes[7*n +: 7] = 7'h1E;
      else                       all_ctl_ok = 1'b0;
    end

    // Terminate in lane k: control bits exactly at lanes >= k, FD in lane k,
    // and only /I/ in the lanes after it.
    term_hit  = 1'b0;
    term_k    = 3'd0;
    tail_idle = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tail_idle = 1'b1;
      for (int j = k + 1; j < 8; j++) begin
        if (lane[j] != 8'h07) tail_idle = 1'b0;
      end
      if ((blk_ctl == (8'hFF << k)) && (lane[k] == 8'hFD) && tail_idle) begin
        term_hit = 1'b1;
        term_k   = 3'(k);
      end
    end

    case (term_k)
      3'd0:    term_type = 8'h87;
      3'd1:    term_type = 8'h99;
      3'd2:    term_type = 8'hAA;
      3'd3:    term_type = 8'hB4;
      3'd4:    term_type = 8'hCC;
      3'd5:    term_type = 8'hD2;
      3'd6:    term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
    term_mask = (64'd1 << {term_k, 3'b000}) - 64'd1;
    term_data = blk_data & term_mask;

    enc_sync    = 2'b10;
    enc_err     = 1'b0;
    if (blk_ctl == 8'h00) begin
      enc_sync    = 2'b01;
      enc_payload = blk_data;
    end else if (blk_ctl == 8'hFF && all_ctl_ok) begin
      enc_payload = {ctl_codes, 8'h1E};
    end else if (blk_ctl == 8'h01 && lane[0] == 8'hFB) begin
      enc_payload = {blk_data[63:8], 8'h78};
    end else if (blk_ctl == 8'h1F && blk_data[31:0] == 32'h0707_0707 && lane[4] == 8'hFB) begin
      // /I/ codes are zero, so C0..C3 and the 4-bit gap are all zero.
      enc_payload = {blk_data[63:40], 32'h0, 8'h33};
    end else if (term_hit) begin
      enc_payload = {term_data[55:0], term_type};
    end else begin
      enc_err     = 1'b1;
      enc_payload = {{8{7'h1E}}, 8'h1E};
    end
  end

  // ---------------- self-synchronising scrambler ----------------
  logic [57:0] scr_s;
  logic [63:0] scr_payload;
  logic        scr_bit;

  always_comb begin
    scr_s       = scr_q;
    scr_payload = enc_payload;
    scr_bit     = 1'b0;
    if (!SCRAMBLE_BYPASS) begin
      for (int i = 0; i < 64; i++) begin
        scr_bit        = enc_payload[i] ^ scr_s[38] ^ scr_s[57];
        scr_payload[i] = scr_bit;
        scr_s          = {scr_s[56:0], scr_bit};
      end
    end
    scr_d = load_blk ? scr_s : scr_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      lo_data_q <= '0;
      lo_ctl_q  <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      scr_q     <= SCRAMBLER_SEED;
      err_cnt_q <= '0;
    end else begin
      scr_q <= scr_d;
      if (capture_lo) begin
        lo_data_q <= pcs_if.in_xgmii_data;
        lo_ctl_q  <= pcs_if.in_xgmii_ctl;
      end
      if (load_blk) begin
        block_q <= {scr_payload, enc_sync};
        valid_q <= 1'b1;
        if (enc_err && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
      end else if (valid_q && pcs_if.in_serdes_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/xgmii_tx_pcs_encoder.md
Name: xgmii_tx_pcs_encoder

Overview:
- 10GBASE-R transmit PCS front end, directly downstream of the 32-bit XGMII transmit MAC.
- Pairs consecutive 32-bit XGMII words into one 64-bit block and applies 64b/66b encoding.
- Scrambles the payload with the x^58+x^39+1 self-synchronising scrambler.
- Presents 66-bit blocks to the gearbox/SERDES stage over a valid/ready handshake.
- Drives the MAC's pcs_ready input for backpressure.

Parameters:
- SCRAMBLE_BYPASS, 0: when 1, the payload passes unscrambled (debug/verification only).
- SCRAMBLER_SEED, 58'h3FF_FFFF_FFFF_FFFF: scrambler state loaded at reset.
- ERR_CNT_WIDTH, 16: width of the saturating encode-error counter.

Ports:
- tx_clk  in  1  transmit clock.
- tx_rst  in  1  reset; synchronous, active-high.
- in_xgmii_data  in  32  XGMII data; lane n = bits [8n+7:8n].
- in_xgmii_ctl  in  4  XGMII control flag per lane.
- out_xgmii_pcs_ready  out  1  word is accepted at every rising edge where this is 1.
- out_pcs_block  out  66  bits [1:0] = sync header; bits [65:2] = scrambled payload, payload bit 0 first.
- out_pcs_valid  out  1  out_pcs_block holds a block.
- in_serdes_ready  in  1  downstream accepts a block when valid && ready.
- out_encode_err_count  out  ERR_CNT_WIDTH  count of error blocks emitted; saturates.

Behaviour:
- Reset (tx_rst=1 at edge) values:
  - out_pcs_valid=0, out_pcs_block=0, out_encode_err_count=0.
  - phase=0; scrambler state=SCRAMBLER_SEED.
  - Reset mid-block discards any captured half-block.
- out_xgmii_pcs_ready = !out_pcs_valid || in_serdes_ready (combinational). It is 0 during reset.
- Phase 0 accept: capture the word as lanes 0-3; phase becomes 1.
- Phase 1 accept: the word forms lanes 4-7. Encode and scramble the block, load the output register, set out_pcs_valid=1, phase becomes 0.
- Latency: the block appears the cycle after its second word is accepted.
- Handshake:
  - If valid && in_serdes_ready with no new load, valid clears.
  - A simultaneous accept-and-load keeps valid=1 and replaces the block.
  - The block is held stable while valid && !ready.
- Sync header: 2'b01 for an all-data block (ctl=8'h00). Otherwise 2'b10.
- Control code mapping: /I/ 8'h07 -> 7'h00; /E/ 8'hFE -> 7'h1E.
- Payload formats (type byte in payload[7:0], lanes ascending in following bits):
  - All data: payload = lanes 0..7.
  - All control (/I/ or /E/ only): type 0x1E, then eight 7-bit codes.
  - Start lane 0 (lane0=FB, ctl=0000_0001): type 0x78, then D1..D7.
  - Start lane 4 (lanes 0-3 control /I/, lane4=FB, ctl=0001_1111): type 0x33, C0..C3 in [35:8], [39:36]=0, D5..D7 in [63:40].
  - Terminate in lane k: lane k=FD with ctl=1; lanes <k are data; lanes >k are /I/.
    - Type by k = 0..7: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF.
    - Then D0..D(k-1); all remaining payload bits are 0.
- Any other pattern emits an error block: type 0x1E with eight 7'h1E codes, sync 2'b10. Examples:
  - an unknown control code;
  - FB outside lane 0/4;
  - data after T;
  - a non-idle control after T;
  - mixed data/control not listed above.
- Each error block increments out_encode_err_count, saturating at all ones.
- Scrambler, per payload bit i=0..63 in order:
  - out = d ^ S[38] ^ S[57];
  - then S <= {S[56:0], out}.
  - The sync header is never scrambled.
  - The state advances only when a block is loaded.
  - With SCRAMBLE_BYPASS=1 the payload is passed through and the state is frozen.
- While out_xgmii_pcs_ready=0: no capture, no phase change, no scrambler advance.

Test Plan:
- Idle pair: reset, BYPASS=1, then two words 32'h07070707 / ctl 4'hF -> out_pcs_block={56'h0,8'h1E,2'b10}, valid one cycle after the 2nd word, err count 0.
- Start + preamble: BYPASS=1, words {55,55,55,FB} ctl 0001 then {D5,55,55,55} ctl 0000 -> payload 64'hD555_5555_5555_5578, sync 2'b10.
- Terminate T4: BYPASS=1, words 32'h44332211 ctl 0 then {07,07,07,FD} ctl 1111 -> payload {24'h0,32'h44332211,8'hCC}, sync 2'b10; repeat for k=0..7 and check all eight type bytes.
- Scrambler: reset, BYPASS=0, two all-zero data words ctl 0 -> sync 2'b01, payload 64'h03FF_FF80_0000_0000.
- Backpressure: hold in_serdes_ready=0 with a block valid -> out_xgmii_pcs_ready=0 and the block is unchanged for 10 cycles. Release -> the next block is correct, with no word lost or duplicated.
- Errors and reset:
  - Send FB in lane 2 -> error block {8×7'h1E,8'h1E,2'b10}, count 1.
  - Force a count of 2^16-1 plus one more error -> the count stays at 16'hFFFF.
  - Assert tx_rst after one word -> valid 0 and phase 0; the next pair encodes correctly.
